// File: rtl/dsp48a1_pkg.sv
// Shared DSP48A1 constants: X/Z select encodings, OPMODE bit positions, datapath widths.
package dsp48a1_pkg;
  localparam int P_W = 48;
  localparam int M_W = 36;

  localparam logic [1:0] X_ZERO = 2'd0;
  localparam logic [1:0] X_M    = 2'd1;
  localparam logic [1:0] X_P    = 2'd2;
  localparam logic [1:0] X_DAB  = 2'd3;

  localparam logic [1:0] Z_ZERO = 2'd0;
  localparam logic [1:0] Z_PCIN = 2'd1;
  localparam logic [1:0] Z_P    = 2'd2;
  localparam logic [1:0] Z_C    = 2'd3;

  localparam int OP_XSEL_LSB = 0;
  localparam int OP_ZSEL_LSB = 2;
  localparam int OP_CIN      = 5;
  localparam int OP_SUB      = 7;
endpackage

// File: rtl/dsp_reg_ce.sv
// Optional pipeline register with clock enable and sync active-high reset (reset beats CE).
// Latency REG cycles (0 = wire); no backpressure, CE simply holds.
module dsp_reg_ce #(
  parameter int W   = 1,
  parameter int REG = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CE,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);
  if (REG != 0) begin : g_reg
    always_ff @(posedge CLK) begin
      if (RST)     Q <= '0;
      else if (CE) Q <= D;
    end
  end else begin : g_bypass
    assign Q = D;
  end
endmodule

// File: rtl/post_adder_stage.sv
// DSP48A1 48-bit post-adder/subtracter: P = Z +/- (X + CIN); latency PREG (data), OPMODEREG (control); no backpressure.
// Optional signed-overflow output OVF under `DSP_POSTADD_OVF_EN.
module post_adder_stage
  import dsp48a1_pkg::*;
#(
  parameter int    OPMODEREG  = 1,
  parameter int    CARRYINREG = 1,
  parameter string CARRYINSEL = "OPMODE5",
  parameter int    PREG       = 1
) (
  input  logic           CLK,
  input  logic           RSTOPMODE,
  input  logic           RSTCARRYIN,
  input  logic           RSTP,
  input  logic           CEOPMODE,
  input  logic           CECARRYIN,
  input  logic           CEP,
  input  logic [7:0]     OPMODE,
  input  logic           CARRYIN,
  input  logic [M_W-1:0] M,
  input  logic [P_W-1:0] DAB,
  input  logic [P_W-1:0] C,
  input  logic [P_W-1:0] PCIN,
  output logic [P_W-1:0] P,
  output logic [P_W-1:0] PCOUT,
  output logic           CARRYOUT
`ifdef DSP_POSTADD_OVF_EN
  ,
  output logic           OVF
`endif
);
  logic [7:0]     op;
  logic           cin_src;
  logic           cin;
  logic [P_W-1:0] x_mux;
  logic [P_W-1:0] z_mux;
  logic [P_W:0]   sum;
  logic [P_W-1:0] s;
  logic           unused_op;

  assign unused_op = ^{op[6], op[4]};

  dsp_reg_ce #(.W(8), .REG(OPMODEREG)) u_opmode_reg (
    .CLK(CLK), .RST(RSTOPMODE), .CE(CEOPMODE), .D(OPMODE), .Q(op)
  );

  // OPMODE5 is taken from the port so it lines up with the OPMODE register sample.
  if (CARRYINSEL == "OPMODE5") begin : g_cin_op5
    assign cin_src = OPMODE[OP_CIN];
  end else if (CARRYINSEL == "CARRYIN") begin : g_cin_port
    assign cin_src = CARRYIN;
  end else begin : g_cin_zero
    assign cin_src = 1'b0;
  end

  dsp_reg_ce #(.W(1), .REG(CARRYINREG)) u_cyi_reg (
    .CLK(CLK), .RST(RSTCARRYIN), .CE(CECARRYIN), .D(cin_src), .Q(cin)
  );

  always_comb begin
    x_mux = '0;
    case (op[OP_XSEL_LSB +: 2])
      X_ZERO:  x_mux = '0;
      X_M:     x_mux = {{(P_W-M_W){M[M_W-1]}}, M};
      X_P:     x_mux = P;
      X_DAB:   x_mux = DAB;
      default: x_mux = '0;
    endcase
  end

  always_comb begin
    z_mux = '0;
    case (op[OP_ZSEL_LSB +: 2])
      Z_ZERO:  z_mux = '0;
      Z_PCIN:  z_mux = PCIN;
      Z_P:     z_mux = P;
      Z_C:     z_mux = C;
      default: z_mux = '0;
    endcase
  end

  // 49-bit wrap: bit 48 is carry on add, borrow on subtract.
  always_comb begin
    if (op[OP_SUB]) sum = {1'b0, z_mux} - ({1'b0, x_mux} + (P_W+1)'(cin));
    else            sum = {1'b0, z_mux} + {1'b0, x_mux} + (P_W+1)'(cin);
  end

  assign s        = sum[P_W-1:0];
  assign CARRYOUT = sum[P_W];

  dsp_reg_ce #(.W(P_W), .REG(PREG)) u_p_reg (
    .CLK(CLK), .RST(RSTP), .CE(CEP), .D(s), .Q(P)
  );

  assign PCOUT = P;

`ifdef DSP_POSTADD_OVF_EN
  logic ovf_comb;
  assign ovf_comb = op[OP_SUB] ? ((x_mux[P_W-1] != z_mux[P_W-1]) && (s[P_W-1] != z_mux[P_W-1]))
                               : ((x_mux[P_W-1] == z_mux[P_W-1]) && (s[P_W-1] != z_mux[P_W-1]));

  dsp_reg_ce #(.W(1), .REG(PREG)) u_ovf_reg (
    .CLK(CLK), .RST(RSTP), .CE(CEP), .D(ovf_comb), .Q(OVF)
  );
`endif

  // Unregistered P feeding back into the adder forms a combinational loop.
  if (PREG == 0) begin : g_loop_chk
    always_comb begin
      assert (op[OP_XSEL_LSB +: 2] != X_P && op[OP_ZSEL_LSB +: 2] != Z_P);
    end
  end
endmodule

// File: tb/tb_post_adder_stage.sv
// Directed bench for post_adder_stage: default instance plus a CARRYINSEL="CARRYIN" instance.
module tb_post_adder_stage;
  logic        CLK = 1'b0;
  logic        RSTOPMODE, RSTCARRYIN, RSTP;
  logic        CEOPMODE, CECARRYIN, CEP;
  logic [7:0]  OPMODE;
  logic        CARRYIN;
  logic [35:0] M;
  logic [47:0] DAB, C, PCIN;
  logic [47:0] P, PCOUT, P2, PCOUT2;
  logic        CARRYOUT, CARRYOUT2;
`ifdef DSP_POSTADD_OVF_EN
  logic        OVF, OVF2;
`endif
  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  post_adder_stage u_dut (
    .CLK(CLK), .RSTOPMODE(RSTOPMODE), .RSTCARRYIN(RSTCARRYIN), .RSTP(RSTP),
    .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN), .CEP(CEP),
    .OPMODE(OPMODE), .CARRYIN(CARRYIN), .M(M), .DAB(DAB), .C(C), .PCIN(PCIN),
    .P(P), .PCOUT(PCOUT), .CARRYOUT(CARRYOUT)
`ifdef DSP_POSTADD_OVF_EN
    , .OVF(OVF)
`endif
  );

  post_adder_stage #(.CARRYINSEL("CARRYIN")) u_dut_ci (
    .CLK(CLK), .RSTOPMODE(RSTOPMODE), .RSTCARRYIN(RSTCARRYIN), .RSTP(RSTP),
    .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN), .CEP(CEP),
    .OPMODE(OPMODE), .CARRYIN(CARRYIN), .M(M), .DAB(DAB), .C(C), .PCIN(PCIN),
    .P(P2), .PCOUT(PCOUT2), .CARRYOUT(CARRYOUT2)
`ifdef DSP_POSTADD_OVF_EN
    , .OVF(OVF2)
`endif
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    RSTOPMODE = 1; RSTCARRYIN = 1; RSTP = 1;
    CEOPMODE = 1; CECARRYIN = 1; CEP = 1;
    OPMODE = 8'h00; CARRYIN = 0; M = '0; DAB = '0; C = '0; PCIN = '0;
    tick();
    chk("rst_p", P, 48'h0);
    chk("rst_pcout", PCOUT, 48'h0);
    chk("rst_cout", {47'b0, CARRYOUT}, 48'h0);
    RSTOPMODE = 0; RSTCARRYIN = 0; RSTP = 0;

    // Add with carry: all-ones + 0 + 1 wraps to 0 with carry out.
    OPMODE = 8'h2F; DAB = 48'hFFFF_FFFF_FFFF; C = 48'h0;
    tick();
    chk("addc_cout_e1", {47'b0, CARRYOUT}, 48'h1);
    tick();
    chk("addc_p_e2", P, 48'h0);
    chk("addc_cout_e2", {47'b0, CARRYOUT}, 48'h1);
    DAB = 48'd5; C = 48'd10;
    tick();
    chk("addc_p_16", P, 48'd16);
    chk("addc_cout_0", {47'b0, CARRYOUT}, 48'h0);

    // Subtract with borrow: 3 - 5, then 10 - 5.
    OPMODE = 8'h8D; M = 36'd5; C = 48'd3;
    tick();
    tick();
    chk("sub_p_neg", P, 48'hFFFF_FFFF_FFFE);
    chk("sub_borrow", {47'b0, CARRYOUT}, 48'h1);
    C = 48'd10;
    tick();
    chk("sub_p_5", P, 48'd5);
    chk("sub_noborrow", {47'b0, CARRYOUT}, 48'h0);

    // M sign extension: 10 + (-3).
    OPMODE = 8'h0D; M = 36'hF_FFFF_FFFD;
    tick();
    tick();
    chk("msext_p", P, 48'd7);
    chk("msext_cout", {47'b0, CARRYOUT}, 48'h1);

    // Accumulate M=7 into P, starting from a cleared P.
    OPMODE = 8'h09; M = 36'd7; CEP = 0; RSTP = 1;
    tick();
    chk("acc_clr", P, 48'd0);
    RSTP = 0; CEP = 1;
    tick(); chk("acc_1", P, 48'd7);
    tick(); chk("acc_2", P, 48'd14);
    tick(); chk("acc_3", P, 48'd21);
    tick(); chk("acc_4", P, 48'd28);
    CEP = 0;
    tick(); chk("acc_hold", P, 48'd28);
    chk("acc_pcout", PCOUT, 48'd28);
    CEP = 1;

    // RSTP together with CEP clears P; accumulation resumes with OPMODE intact.
    RSTP = 1;
    tick(); chk("rstp_cep", P, 48'd0);
    RSTP = 0;
    tick(); chk("resume_1", P, 48'd7);
    tick(); chk("resume_2", P, 48'd14);

    // RSTOPMODE mid-accumulation: one cycle of op=0 gives S=0.
    RSTOPMODE = 1;
    tick(); chk("rstop_e1", P, 48'd21);
    RSTOPMODE = 0;
    tick(); chk("rstop_e2", P, 48'd0);
    tick(); chk("rstop_e3", P, 48'd7);

    // RSTCARRYIN drops CIN for one cycle only.
    OPMODE = 8'h20;
    tick();
    tick(); chk("cyi_p1", P, 48'd1);
    RSTCARRYIN = 1;
    tick(); chk("cyi_rst_e1", P, 48'd1);
    RSTCARRYIN = 0;
    tick(); chk("cyi_rst_e2", P, 48'd0);
    tick(); chk("cyi_rst_e3", P, 48'd1);

    // Cascade with external carry-in on the CARRYIN-select instance.
    OPMODE = 8'h07; PCIN = 48'd100; DAB = 48'd1; CARRYIN = 0;
    tick();
    tick(); chk("casc_base", P2, 48'd101);
    CARRYIN = 1;
    tick(); chk("casc_cyi_cap", P2, 48'd101);
    CARRYIN = 0;
    tick(); chk("casc_pulse", P2, 48'd102);
    chk("casc_op5_inst", P, 48'd101);
    tick(); chk("casc_after", P2, 48'd101);
    chk("casc_pcout", PCOUT2, 48'd101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
